// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter that shares one toggle-handshake CDC channel among N requesters.
// Optional WAIT timeout flag when CDC_HS_TMO_EN is defined.
//
// Ports:
//   clk, rst     source clock, synchronous active-high reset
//   req_i        per-requester level request
//   data_i       per-requester word, slice k = data_i[k*DW +: DW]
//   gnt_o        one-hot grant, high from LOAD until done
//   done_o       one-cycle completion pulse to the winner
//   busy_o       high whenever the FSM is not IDLE
//   cdc_data_o   launched word, held from grant until the next grant
//   cdc_req_o    request toggle towards the far domain
//   cdc_ack_i    asynchronous ack toggle from the far domain
//   tmo_o        sticky WAIT timeout flag (tied 0 without CDC_HS_TMO_EN)
//   tmo_clr_i    clears tmo_o
module cdc_hs_arbiter #(
    parameter int N            = 4,
    parameter int DW           = 32,
    parameter int DEST_SYNC_FF = 2,
    parameter int TMO_CYC      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    done_o,
    output logic            busy_o,
    output logic [DW-1:0]   cdc_data_o,
    output logic            cdc_req_o,
    input  logic            cdc_ack_i,
    output logic            tmo_o,
    input  logic            tmo_clr_i
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_nxt;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic [PW:0]     idx;
    logic [DW-1:0]   win_data;
    logic [N-1:0]    gnt_nxt;
    logic [N-1:0]    done_nxt;
    logic [DW-1:0]   data_nxt;
    logic            req_nxt;
    logic            ack_s;

    // Ack synchronizer: DEST_SYNC_FF flops, intentionally not reset so a
    // reset in one domain never fabricates an ack edge.
    logic [DEST_SYNC_FF-1:0] ack_sync;

    always_ff @(posedge clk) begin
        ack_sync <= {ack_sync[DEST_SYNC_FF-2:0], cdc_ack_i};
    end

    assign ack_s  = ack_sync[DEST_SYNC_FF-1];
    assign busy_o = (state != IDLE);

    // First requester at or above rr_ptr, wrapping at N-1.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!win_vld && req_i[idx[PW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win == PW'(i)) begin
                win_data = data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        done_nxt  = '0;
        data_nxt  = cdc_data_o;
        req_nxt   = cdc_req_o;
        rr_nxt    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    data_nxt     = win_data;
                    rr_nxt       = (win == PW'(N-1)) ? '0 : win + 1'b1;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                req_nxt   = ~cdc_req_o;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Level compare: an ack that arrived early is still seen.
                if (ack_s == cdc_req_o) begin
                    done_nxt  = gnt_o;
                    gnt_nxt   = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_o      <= '0;
            done_o     <= '0;
            cdc_data_o <= '0;
            cdc_req_o  <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            gnt_o      <= gnt_nxt;
            done_o     <= done_nxt;
            cdc_data_o <= data_nxt;
            cdc_req_o  <= req_nxt;
            rr_ptr     <= rr_nxt;
        end
    end

`ifdef CDC_HS_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_set;

    // The flag only reports; the handshake itself is never aborted.
    assign tmo_set = (state == WAIT) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_o   <= 1'b0;
        end else begin
            if (state == LOAD) begin
                tmo_cnt <= '0;
            end else if (state == WAIT && tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_set) begin
                tmo_o <= 1'b1;
            end else if (tmo_clr_i) begin
                tmo_o <= 1'b0;
            end
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = tmo_clr_i ^ (TMO_CYC < 0);
    assign tmo_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Randomized bench for cdc_hs_arbiter with a far-domain ack echo model
// and a transaction-level round-robin reference.
module tb_cdc_hs_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

`ifdef CDC_HS_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int F_NORM = 0;
    localparam int F_HOLD = 1;
    localparam int F_RST  = 2;
    localparam int F_SPUR = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*DW-1:0] data_i = '0;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    done_o;
    logic            busy_o;
    logic [DW-1:0]   cdc_data_o;
    logic            cdc_req_o;
    logic            cdc_ack_i = 1'b0;
    logic            tmo_o;
    logic            tmo_clr_i = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int m_ptr = 0;
    bit m_par = 1'b0;
    int far_mode = F_RST;
    int ack_dly = 3;
    bit far_seen = 1'b0;
    int far_cnt = 0;

    cdc_hs_arbiter #(
        .N(N), .DW(DW), .DEST_SYNC_FF(2), .TMO_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i),
        .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
        .cdc_data_o(cdc_data_o), .cdc_req_o(cdc_req_o),
        .cdc_ack_i(cdc_ack_i), .tmo_o(tmo_o), .tmo_clr_i(tmo_clr_i)
    );

    always #5 clk = ~clk;

    // Far domain: echoes each new request level after ack_dly clocks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (far_mode == F_RST) begin
                far_seen  = 1'b0;
                cdc_ack_i = 1'b0;
                far_cnt   = 0;
            end else if (far_mode == F_SPUR) begin
                cdc_ack_i = ~far_seen;
            end else if (far_mode == F_HOLD) begin
                far_cnt = 0;
            end else if (cdc_req_o == far_seen) begin
                cdc_ack_i = far_seen;
                far_cnt   = 0;
            end else begin
                far_cnt++;
                if (far_cnt >= ack_dly) begin
                    far_seen  = cdc_req_o;
                    cdc_ack_i = far_seen;
                    far_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic rand_data();
        data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // One complete transfer, starting with the DUT in IDLE.
    task automatic xfer(input logic [N-1:0] r, input logic [N-1:0] ra,
                        input string tag, output int w);
        logic [N-1:0]  oh;
        logic [DW-1:0] d;
        bit            seen;
        w  = pick(r);
        oh = '0;
        oh[w] = 1'b1;
        d  = data_i[w*DW +: DW];
        req_i = r;
        tick();
        m_ptr = (w + 1) % N;
        chk({tag, "_gnt"}, gnt_o, oh);
        chk({tag, "_data"}, cdc_data_o, d);
        chk({tag, "_busy"}, busy_o, 1);
        chk({tag, "_req0"}, cdc_req_o, m_par);
        req_i = ra;
        rand_data();
        tick();
        m_par = ~m_par;
        chk({tag, "_req1"}, cdc_req_o, m_par);
        chk({tag, "_hold"}, cdc_data_o, d);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (done_o != '0) begin
                seen = 1'b1;
                chk({tag, "_done"}, done_o, oh);
                chk({tag, "_gntoff"}, gnt_o, 0);
                chk({tag, "_acked"}, far_seen == m_par, 1);
                chk({tag, "_busyd"}, busy_o, 1);
            end else begin
                chk({tag, "_gntw"}, gnt_o, oh);
                chk({tag, "_dataw"}, cdc_data_o, d);
            end
        end
        if (!seen) chk({tag, "_nodone"}, 0, 1);
        tick();
        chk({tag, "_pulse"}, done_o, 0);
        chk({tag, "_idle"}, busy_o, 0);
        chk({tag, "_tmo"}, tmo_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = '0;
        far_mode = F_RST;
        tick();
        tick();
        rst = 1'b0;
        far_mode = F_NORM;
        m_ptr = 0;
        m_par = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int w;
        int exp_rr[5];
        logic [N-1:0] r;
        logic [N-1:0] oh;
        bit seen;
        exp_rr = '{0, 1, 2, 3, 0};

        // T1 reset
        tick();
        tick();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", cdc_data_o, 0);
        chk("rst_req", cdc_req_o, 0);
        chk("rst_tmo", tmo_o, 0);
        rst = 1'b0;
        far_mode = F_NORM;
        repeat (3) tick();

        // T2 single
        rand_data();
        data_i[2*DW +: DW] = 32'hDEADBEEF;
        xfer(4'b0100, 4'b0100, "single", w);
        chk("single_win", w, 2);
        req_i = '0;
        tick();

        // T3 round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_data();
            xfer(4'b1111, 4'b1111, "rr", w);
            chk("rr_order", w, exp_rr[i]);
        end
        chk("rr_par", cdc_req_o, 1);
        req_i = '0;
        tick();

        // T4 withdrawal: req1 drops after grant, req3 drops before arbitration
        xfer(4'b1010, 4'b0000, "wd", w);
        chk("wd_win", w, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wd_nognt", gnt_o, 0);
            chk("wd_nobusy", busy_o, 0);
        end

        // T5 spurious ack pulse while IDLE
        far_mode = F_SPUR;
        tick();
        tick();
        far_mode = F_NORM;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("spur_done", done_o, 0);
            chk("spur_busy", busy_o, 0);
        end
        xfer(4'b0001, 4'b0001, "spur", w);
        chk("spur_win", w, 0);
        req_i = '0;
        tick();

        // Reset in the middle of WAIT
        far_mode = F_HOLD;
        req_i = 4'b0010;
        repeat (5) tick();
        chk("mr_busy0", busy_o, 1);
        rst = 1'b1;
        req_i = '0;
        far_mode = F_RST;
        tick();
        rst = 1'b0;
        far_mode = F_NORM;
        chk("mr_gnt", gnt_o, 0);
        chk("mr_req", cdc_req_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_data", cdc_data_o, 0);
        m_ptr = 0;
        m_par = 1'b0;
        repeat (4) tick();

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            ack_dly = $urandom_range(1, 6);
            r = 4'($urandom_range(1, 15));
            rand_data();
            xfer(r, r & 4'($urandom_range(0, 15)), "rnd", w);
            if ($urandom_range(0, 3) == 0) begin
                req_i = '0;
                tick();
                chk("rnd_idle", busy_o, 0);
            end
        end
        req_i = '0;
        tick();

        // T6 withheld ack
        ack_dly = 3;
        far_mode = F_HOLD;
        w = pick(4'b0001);
        oh = 4'b0001;
        req_i = 4'b0001;
        tick();
        m_ptr = (w + 1) % N;
        req_i = '0;
        tick();
        m_par = ~m_par;
        chk("t6_req", cdc_req_o, m_par);
        repeat (60) tick();
        chk("t6_tmo60", tmo_o, 0);
        repeat (10) tick();
        chk("t6_tmo70", tmo_o, TMO_EN);
        chk("t6_gnt", gnt_o, oh);
        far_mode = F_NORM;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (done_o != '0) begin
                seen = 1'b1;
                chk("t6_done", done_o, oh);
            end
        end
        if (!seen) chk("t6_nodone", 0, 1);
        tick();
        chk("t6_sticky", tmo_o, TMO_EN);
        chk("t6_idle", busy_o, 0);
        tmo_clr_i = 1'b1;
        tick();
        tmo_clr_i = 1'b0;
        chk("t6_clr", tmo_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
